// File: rtl/demux4_rr_dispatcher.sv
// demux4_rr_dispatcher: accepts a word stream on a valid/ready input and
// dispatches each word to one of four output channels. The channel is
// either taken from a round-robin pointer or given explicitly with the word.
// One word is held in an output register until its channel accepts it.
// Round-robin words stalled for TIMEOUT cycles move on to the next channel.

module demux4_rr_dispatcher #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_addr_en,
  input  logic [1:0]        in_dest,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [CNT_W-1:0]  resteer_cnt
);

  // Stall counter only has to reach TIMEOUT-1; keep at least one bit.
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit RESTEER_EN = (TIMEOUT != 0);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                rr_word_q, rr_word_d;
  logic [CNT_W-1:0]    rs_cnt_q, rs_cnt_d;

  logic holding;
  logic deliver;
  logic accept;
  logic timeout_hit;

  // Handshake terms. Accepting in the same cycle as a delivery gives
  // back-to-back transfers without a bubble; in_ready is forced low in reset.
  assign holding     = (state_q == HOLD);
  assign deliver     = holding & out_ready[sel_q];
  assign in_ready    = rst_n & (~holding | deliver);
  assign accept      = in_valid & in_ready;
  // Only round-robin words re-steer, and a delivery in the timeout cycle wins.
  assign timeout_hit = RESTEER_EN & holding & rr_word_q & ~deliver & (tcnt_q == TCNT_LAST);

  // Output decode: one-hot valid for the addressed channel while a word is held.
  always_comb begin
    out_valid = 4'b0000;
    if (holding) out_valid = 4'b0001 << sel_q;
  end

  assign out_data    = data_q;
  assign sel         = sel_q;
  assign busy        = holding;
  assign resteer_cnt = rs_cnt_q;

  // Next-state logic: load on accept, release on deliver, count or re-steer on stall.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // branches below leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    data_d    = data_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    tcnt_d    = tcnt_q;
    rr_word_d = rr_word_q;
    rs_cnt_d  = rs_cnt_q;

    if (accept) begin
      state_d   = HOLD;
      data_d    = in_data;
      tcnt_d    = '0;
      rr_word_d = ~in_addr_en;
      if (in_addr_en) begin
        sel_d = in_dest;
      end else begin
        sel_d = ptr_q;
        ptr_d = ptr_q + 2'd1;
      end
    end else if (deliver) begin
      state_d = IDLE;
    end else if (timeout_hit) begin
      sel_d  = sel_q + 2'd1;
      tcnt_d = '0;
      if (rs_cnt_q != '1) rs_cnt_d = rs_cnt_q + 1'b1;
    end else if (holding) begin
      // Addressed words may wait forever; stop at all-ones rather than wrap.
      if (tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
    end
  end

  // State register with asynchronous reset; a held word is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      // NOTE: the data register is reset too so out_data reads 0 after reset,
      // not whatever was left over from before.
      data_q    <= '0;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd0;
      tcnt_q    <= '0;
      rr_word_q <= 1'b0;
      rs_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous cycle, independent of statement order.
      state_q   <= state_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      tcnt_q    <= tcnt_d;
      rr_word_q <= rr_word_d;
      rs_cnt_q  <= rs_cnt_d;
    end
  end

endmodule

// File: tb/tb_demux4_rr_dispatcher.sv
// Self-checking bench for demux4_rr_dispatcher: directed scenarios followed by
// a randomized run, all compared every cycle against a transaction-level model.

module tb_demux4_rr_dispatcher;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_addr_en;
  logic [1:0]        in_dest;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [1:0]        sel;
  logic              busy;
  logic [CNT_W-1:0]  resteer_cnt;

  demux4_rr_dispatcher #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr_en (in_addr_en),
    .in_dest    (in_dest),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sel        (sel),
    .busy       (busy),
    .resteer_cnt(resteer_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Deliveries seen on the outputs: {data, one-hot channel}.
  logic [DATA_W+3:0] dlv_q[$];

  // Reference model: the held word (if any), its channel, whether it was
  // round-robin, how long it has waited, the round-robin pointer, re-steers.
  bit         m_held;
  logic [7:0] m_data;
  int         m_ch;
  bit         m_rr;
  int         m_wait;
  int         m_ptr;
  int         m_resteers;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_data = '0; m_ch = 0; m_rr = 0;
    m_wait = 0; m_ptr = 0; m_resteers = 0;
  endtask

  function automatic logic [3:0] model_valid();
    return m_held ? 4'(1 << m_ch) : 4'b0000;
  endfunction

  // Compare all outputs against the model at the falling edge, log any
  // delivery, advance the model by the spec rules, then step past the rising edge.
  task automatic cycle();
    bit exp_ready, dlv, acc;
    @(negedge clk);
    exp_ready = !m_held || out_ready[m_ch];
    check("out_valid", 32'(out_valid), 32'(model_valid()));
    check("out_data", 32'(out_data), 32'(m_data));
    check("sel", 32'(sel), 32'(m_ch));
    check("busy", 32'(busy), 32'(m_held));
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("resteer_cnt", 32'(resteer_cnt), 32'(m_resteers));
    if ((out_valid & out_ready) != 4'b0000) dlv_q.push_back({out_data, out_valid});
    dlv = m_held && out_ready[m_ch];
    acc = in_valid && exp_ready;
    if (acc) begin
      m_held = 1; m_data = in_data; m_wait = 0; m_rr = !in_addr_en;
      if (in_addr_en) m_ch = int'(in_dest);
      else begin
        m_ch  = m_ptr;
        m_ptr = (m_ptr + 1) % 4;
      end
    end else if (dlv) begin
      m_held = 0;
    end else if (m_held) begin
      m_wait++;
      if (m_rr && TIMEOUT != 0 && m_wait == TIMEOUT) begin
        m_ch   = (m_ch + 1) % 4;
        m_wait = 0;
        if (m_resteers < (1 << CNT_W) - 1) m_resteers++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_addr_en = 0; in_dest = 0; in_data = '0;
    rst_n = 0;
    model_reset();
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    dlv_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input bit addr, input logic [1:0] dest);
    in_data = d; in_addr_en = addr; in_dest = dest; in_valid = 1;
    cycle();
    in_valid = 0;
  endtask

  task automatic check_dlv(input string tag, input int idx, input logic [7:0] d, input logic [3:0] v);
    if (idx < dlv_q.size()) check(tag, 32'(dlv_q[idx]), 32'({d, v}));
    else check(tag, 32'hDEAD, 32'({d, v}));
  endtask

  initial begin
    logic [7:0] rr_words[5];
    logic [3:0] rr_ch[5];
    out_ready = 4'b1111;
    rst_n = 0;
    in_valid = 0; in_addr_en = 0; in_dest = 0; in_data = '0;
    @(posedge clk);
    #1;
    do_reset();
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);

    // Round-robin burst: channels 0,1,2,3,0 with no bubbles.
    rr_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rr_ch    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    in_valid = 1; in_addr_en = 0;
    for (int i = 0; i < 5; i++) begin
      in_data = rr_words[i];
      check("burst_in_ready", 32'(in_ready), 32'd1);
      cycle();
    end
    in_valid = 0;
    cycle();
    check("burst_count", 32'(dlv_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) check_dlv("burst_dlv", i, rr_words[i], rr_ch[i]);

    // Addressed words to channel 2, then an RR word to channel 0.
    do_reset();
    in_valid = 1; in_addr_en = 1; in_dest = 2'd2; in_data = 8'hA0;
    cycle();
    in_data = 8'hA1;
    cycle();
    in_addr_en = 0; in_data = 8'hB0;
    cycle();
    in_valid = 0;
    cycle();
    check_dlv("addr_a0", 0, 8'hA0, 4'b0100);
    check_dlv("addr_a1", 1, 8'hA1, 4'b0100);
    check_dlv("addr_b0", 2, 8'hB0, 4'b0001);

    // Backpressure on channel 1 leads to a re-steer after TIMEOUT cycles.
    do_reset();
    out_ready = 4'b1101;
    send(8'h01, 0, 2'd0);
    send(8'h5A, 0, 2'd0);
    for (int i = 0; i < TIMEOUT; i++) begin
      check("stall_valid", 32'(out_valid), 32'b0010);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      cycle();
    end
    check("resteer_valid", 32'(out_valid), 32'b0100);
    check("resteer_cnt1", 32'(resteer_cnt), 32'd1);
    cycle();
    check_dlv("resteer_dlv", 1, 8'h5A, 4'b0100);

    // Channel 1 becomes ready exactly in the timeout cycle: delivery wins.
    do_reset();
    out_ready = 4'b1101;
    send(8'h01, 0, 2'd0);
    send(8'h6B, 0, 2'd0);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      check("coll_sel", 32'(sel), 32'd1);
      cycle();
    end
    out_ready = 4'b1111;
    cycle();
    check_dlv("coll_dlv", 1, 8'h6B, 4'b0010);
    check("coll_resteer", 32'(resteer_cnt), 32'd0);
    check("coll_sel_after", 32'(sel), 32'd1);

    // Addressed word stalled for 100 cycles never re-steers.
    do_reset();
    out_ready = 4'b0111;
    send(8'hC3, 1, 2'd3);
    for (int i = 0; i < 100; i++) begin
      check("astall_valid", 32'(out_valid), 32'b1000);
      cycle();
    end
    check("astall_resteer", 32'(resteer_cnt), 32'd0);
    out_ready = 4'b1111;
    cycle();
    check_dlv("astall_dlv", 0, 8'hC3, 4'b1000);

    // Asynchronous reset while holding a word for channel 1.
    do_reset();
    out_ready = 4'b1101;
    send(8'h01, 0, 2'd0);
    send(8'h7E, 0, 2'd0);
    cycle();
    check("prerst_valid", 32'(out_valid), 32'b0010);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    dlv_q.delete();
    out_ready = 4'b1111;
    send(8'h99, 0, 2'd0);
    cycle();
    check_dlv("arst_next", 0, 8'h99, 4'b0001);

    // Randomized traffic with stretches of constant backpressure.
    do_reset();
    for (int blk = 0; blk < 120; blk++) begin
      logic [3:0] rdy;
      int len;
      rdy = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      len = $urandom_range(1, 24);
      for (int c = 0; c < len; c++) begin
        out_ready  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : rdy;
        in_valid   = ($urandom_range(0, 2) != 0);
        in_addr_en = ($urandom_range(0, 3) == 0);
        in_dest    = 2'($urandom);
        in_data    = 8'($urandom);
        cycle();
      end
    end
    in_valid = 0;
    out_ready = 4'b1111;
    cycle();
    check("final_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux4_rr_dispatcher.md
Name: demux4_rr_dispatcher

Overview:
- Sequencing controller for the 1-to-4 demultiplexer datapath. Accepts a word stream on a valid/ready input and dispatches each word to one of four output channels.
- Channel choice is either a round-robin pointer or an explicit per-word destination.
- Holds one word in an output register until the selected channel accepts it.
- Words dispatched round-robin are re-steered to the next channel if the target stalls longer than a timeout.

Parameters:
- DATA_W, 8: width of the data word.
- TIMEOUT, 16: stall cycles before a round-robin word is re-steered. 0 disables re-steering.
- CNT_W, 8: width of the saturating re-steer counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  input word.
- in_valid  in  1  input word present.
- in_ready  out  1  dispatcher can accept a word this cycle.
- in_addr_en  in  1  1 = use in_dest; 0 = use round-robin pointer. Sampled with the word.
- in_dest  in  2  explicit destination channel (0..3) when in_addr_en=1.
- out_data  out  DATA_W  registered word, shared by all channels.
- out_valid  out  4  one-hot valid; bit k = word offered to channel k.
- out_ready  in  4  per-channel ready.
- sel  out  2  channel currently addressed (drives the demux select lines).
- busy  out  1  a word is held (state HOLD).
- resteer_cnt  out  CNT_W  saturating count of timeout re-steers.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; out_data=0; sel=0.
  - Round-robin pointer ptr=0; stall counter tcnt=0; rr_word flag=0; resteer_cnt=0.
  - in_ready=0 while rst_n=0. Reset mid-transfer discards the held word silently.
- Definitions:
  - Accept = in_valid & in_ready.
  - Deliver = out_valid[sel] & out_ready[sel].
- States: IDLE, HOLD.
- in_ready (combinational) = rst_n & (state==IDLE | Deliver). This allows back-to-back transfers with no bubble.
- On Accept (next edge):
  - out_data <= in_data; state <= HOLD; tcnt <= 0; rr_word <= ~in_addr_en.
  - sel <= in_addr_en ? in_dest : ptr.
  - If in_addr_en=0: ptr <= ptr+1 mod 4 (3 wraps to 0). Addressed words leave ptr unchanged.
- Latency: word accepted at edge N appears on out_data/out_valid after edge N. Minimum 1 cycle input-to-output.
- HOLD:
  - out_valid = one-hot(sel); busy=1; out_data and sel stable until Deliver or re-steer.
  - Deliver without Accept: state <= IDLE, out_valid <= 0.
  - Deliver with Accept: the new word loads and the state stays HOLD.
  - No Deliver: tcnt <= tcnt+1.
- Re-steer:
  - Condition: TIMEOUT!=0, rr_word=1, no Deliver, tcnt==TIMEOUT-1.
  - Action: sel <= sel+1 mod 4; tcnt <= 0; resteer_cnt <= sat+1 (holds at 2^CNT_W-1).
  - ptr is not modified. out_valid moves to the new channel on the next cycle.
- Deliver in the same cycle as the timeout: Deliver wins, no re-steer.
- Addressed words (rr_word=0) wait indefinitely; tcnt still counts but has no effect.
- out_valid never has more than one bit set. out_valid=0 in IDLE.
- out_ready bits of non-selected channels are ignored.

Test Plan:
- Reset, then in_addr_en=0 and in_valid=1 with data 0x11,0x22,0x33,0x44,0x55, all out_ready=1:
  - Words appear on channels 0,1,2,3,0 on consecutive cycles.
  - in_ready stays 1 and there are no bubbles.
- Addressed: send 0xA0 to dest 2, then 0xA1 to dest 2, then one RR word 0xB0:
  - 0xA0 and 0xA1 appear with out_valid=4'b0100.
  - RR word 0xB0 goes to channel 0 (ptr unmoved).
- Backpressure: out_ready[1]=0 with an RR word for channel 1, TIMEOUT=16:
  - out_valid=4'b0010 held for 16 cycles, then 4'b0100; resteer_cnt=1.
  - in_ready=0 throughout the stall.
- Timeout collision: out_ready[1] rises in exactly the timeout cycle:
  - Word delivered on channel 1; resteer_cnt unchanged; sel never becomes 2.
- Addressed stall: dest 3 with out_ready[3]=0 for 100 cycles:
  - No re-steer; out_valid=4'b1000 throughout; delivered once ready=1.
- Reset mid-HOLD: assert rst_n=0 while out_valid=4'b0010:
  - out_valid=0, sel=0, in_ready=0 immediately (asynchronously).
  - After release, next RR word goes to channel 0.
